// File: rtl/bloom_pkg.sv
// =============================================================================
// bloom_pkg: row-layout constants, log2 helper and default row type for the
//            time-decaying Bloom filter memory.  Rev 1.0
// =============================================================================
`default_nettype none

package bloom_pkg;

  // Ceiling log2, never below 1 so that index fields always have a bit.
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Row layout is {bloom, bucket, loop} with loop at the bottom.
  function automatic int bucket_lsb(input int loop_w);
    return loop_w;
  endfunction

  function automatic int bloom_lsb(input int loop_w, input int bidx_w);
    return loop_w + bidx_w;
  endfunction

  localparam int DEF_NUM_BUCKETS = 12;
  localparam int DEF_BUCKET_SZ   = 4;
  localparam int DEF_LOOP_W      = 12;
  localparam int DEF_BIDX_W      = log2(DEF_NUM_BUCKETS);
  localparam int DEF_BLOOM_W     = DEF_NUM_BUCKETS * DEF_BUCKET_SZ;
  localparam int DEF_DATA_WIDTH  = DEF_BLOOM_W + DEF_BIDX_W + DEF_LOOP_W;

  typedef struct packed {
    logic [DEF_BLOOM_W-1:0] bloom;
    logic [DEF_BIDX_W-1:0]  bucket;
    logic [DEF_LOOP_W-1:0]  loop;
  } row_t;

endpackage

`default_nettype wire

// File: rtl/bloom_age_shift.sv
// =============================================================================
// bloom_age_shift: bucket-granular right shift with clear and saturating
//                  increment of the newest (top) bucket.  Rev 1.0
// =============================================================================
`default_nettype none

module bloom_age_shift
  import bloom_pkg::*;
#(
  parameter int NUM_BUCKETS = DEF_NUM_BUCKETS,
  parameter int BUCKET_SZ   = DEF_BUCKET_SZ,
  parameter int EW          = log2(NUM_BUCKETS) + 1,
  parameter int BLOOM_W     = NUM_BUCKETS * BUCKET_SZ
)(
  input  logic [BLOOM_W-1:0] bloom_in,
  input  logic [EW-1:0]      elapsed,
  input  logic               clear,
  input  logic               insert,
  output logic [BLOOM_W-1:0] bloom_out
);

  logic [BLOOM_W-1:0]   aged;
  logic [BUCKET_SZ-1:0] top;

  // One constant shift per possible elapsed count, selected by a mux.
  always_comb begin
    aged = '0;
    if (!clear) begin
      for (int k = 0; k < NUM_BUCKETS; k++) begin
        if (elapsed == EW'(k)) aged = bloom_in >> (k * BUCKET_SZ);
      end
    end
  end

  always_comb begin
    top       = aged[BLOOM_W-1 -: BUCKET_SZ];
    bloom_out = aged;
    if (insert && (top != {BUCKET_SZ{1'b1}})) begin
      bloom_out[BLOOM_W-1 -: BUCKET_SZ] = top + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/atualiza_linha_pipe.sv
// =============================================================================
// atualiza_linha_pipe: two-stage row-ageing engine between the filter RAM
//                      read port and its write-back path.  Rev 1.0
// =============================================================================
`default_nettype none

module atualiza_linha_pipe
  import bloom_pkg::*;
#(
  parameter int NUM_BUCKETS = DEF_NUM_BUCKETS,
  parameter int BUCKET_SZ   = DEF_BUCKET_SZ,
  parameter int LOOP_W      = DEF_LOOP_W,
  parameter int BIDX_W      = log2(NUM_BUCKETS),
  parameter int BLOOM_W     = NUM_BUCKETS * BUCKET_SZ,
  parameter int DATA_WIDTH  = BLOOM_W + BIDX_W + LOOP_W,
  parameter bit WRAP_EN     = 1'b1,
  parameter int CNT_W       = 16
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_insert,
  input  logic [BIDX_W-1:0]     in_bucket,
  input  logic [LOOP_W-1:0]     in_loop,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      clr_cnt,
  input  logic                  clr_stats
);

  localparam int            EW      = BIDX_W + 1;
  localparam int            BKT_LSB = bucket_lsb(LOOP_W);
  localparam int            BLM_LSB = bloom_lsb(LOOP_W, BIDX_W);
  localparam logic [EW-1:0] NB      = EW'(NUM_BUCKETS);

  logic [BLOOM_W-1:0] row_bloom;
  logic [BIDX_W-1:0]  row_bkt;
  logic [LOOP_W-1:0]  row_loop;
  logic [LOOP_W-1:0]  loop_diff;
  logic [EW-1:0]      elapsed;
  logic               row_clr;
  logic               row_err;

  assign row_bloom = in_data[BLM_LSB +: BLOOM_W];
  assign row_bkt   = in_data[BKT_LSB +: BIDX_W];
  assign row_loop  = in_data[LOOP_W-1:0];
  assign loop_diff = in_loop - row_loop;

  // Elapsed buckets only need the same-loop and next-loop cases; any larger
  // loop gap has expired every bucket, so no multiply by NUM_BUCKETS.
  always_comb begin
    elapsed = '0;
    row_clr = 1'b0;
    row_err = 1'b0;
    if (({1'b0, row_bkt} >= NB) || ({1'b0, in_bucket} >= NB)) row_err = 1'b1;
    if (!WRAP_EN && (row_loop > in_loop)) row_err = 1'b1;
    if (loop_diff == '0) begin
      if (in_bucket < row_bkt) row_err = 1'b1;
      elapsed = {1'b0, in_bucket} - {1'b0, row_bkt};
    end else if (loop_diff == LOOP_W'(1)) begin
      elapsed = NB - {1'b0, row_bkt} + {1'b0, in_bucket};
    end else begin
      row_clr = 1'b1;
    end
    if (elapsed >= NB) row_clr = 1'b1;
  end

  logic s1_vld, s1_en, s2_en;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [BIDX_W-1:0]     s1_bucket;
  logic [LOOP_W-1:0]     s1_loop;
  logic [EW-1:0]         s1_elapsed;
  logic                  s1_clr, s1_err, s1_ins;

  assign s2_en  = !out_vld || out_rdy;
  assign s1_en  = !s1_vld || s2_en;
  assign in_rdy = s1_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld     <= 1'b0;
      s1_data    <= '0;
      s1_bucket  <= '0;
      s1_loop    <= '0;
      s1_elapsed <= '0;
      s1_clr     <= 1'b0;
      s1_err     <= 1'b0;
      s1_ins     <= 1'b0;
    end else if (s1_en) begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_data    <= in_data;
        s1_bucket  <= in_bucket;
        s1_loop    <= in_loop;
        s1_elapsed <= elapsed;
        s1_clr     <= row_clr;
        s1_err     <= row_err;
        s1_ins     <= in_insert;
      end
    end
  end

  logic [BLOOM_W-1:0] aged_bloom;
  logic               out_clr;

  bloom_age_shift #(
    .NUM_BUCKETS (NUM_BUCKETS),
    .BUCKET_SZ   (BUCKET_SZ),
    .EW          (EW),
    .BLOOM_W     (BLOOM_W)
  ) u_age_shift (
    .bloom_in  (s1_data[BLM_LSB +: BLOOM_W]),
    .elapsed   (s1_elapsed),
    .clear     (s1_clr),
    .insert    (s1_ins),
    .bloom_out (aged_bloom)
  );

  // Error rows are written back untouched, so no insert leaks into them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_err  <= 1'b0;
      out_clr  <= 1'b0;
    end else if (s2_en) begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        out_data <= s1_err ? s1_data : {aged_bloom, s1_bucket, s1_loop};
        out_err  <= s1_err;
        out_clr  <= s1_clr && !s1_err;
      end
    end
  end

  logic drain;
  assign drain = out_vld && out_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
      clr_cnt <= '0;
    end else if (clr_stats) begin
      err_cnt <= '0;
      clr_cnt <= '0;
    end else if (drain) begin
      if (out_err && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
      if (out_clr && (clr_cnt != {CNT_W{1'b1}})) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^row_bloom;

endmodule

`default_nettype wire
